life_frame_reader: RTL

//  Read-side companion to the life array write port (val/write_enb): snapshots the

---
 rtl/life_frame_reader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/life_frame_reader.sv
// life_frame_reader
//   Read-side companion to the life array. On a start request in IDLE it
//   snapshots the current generation, records its population count and whether
//   it equals the previous generation, then streams the snapshot out one row
//   per valid/ready transfer. A one-cycle done pulse follows the last row.
//
// Ports
//   clk         system clock, all state on the rising edge
//   reset       asynchronous, active-high reset
//   alive       current generation, bit COLS*i+j = row i, col j
//   alive_prev  previous generation, same bit mapping
//   start       frame read request, honoured only in IDLE
//   busy        high while a frame is in SEND or DONE
//   out_valid   out_data/out_row/out_last carry a row
//   out_ready   sink accepts a row when out_valid & out_ready
//   out_data    row word, out_data[j] = snapshot[COLS*row+j]
//   out_row     index of the row on out_data
//   out_last    marks the final row of the frame
//   pop_count   number of live cells in the snapshot
//   stable      snapshot alive equals snapshot alive_prev
//   done        one-cycle pulse after the last row is accepted
module life_frame_reader #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int RW   = 2,
    parameter int PW   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] alive,
    input  logic [ROWS*COLS-1:0] alive_prev,
    input  logic                 start,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COLS-1:0]      out_data,
    output logic [RW-1:0]        out_row,
    output logic                 out_last,
    output logic [PW-1:0]        pop_count,
    output logic                 stable,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    state_t               state;
    logic [ROWS*COLS-1:0] snap_alive;
    logic [RW-1:0]        next_row;

    assign next_row = out_row + 1'b1;

    function automatic logic [PW-1:0] popcount(input logic [ROWS*COLS-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < ROWS * COLS; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    // Single frame FSM. out_row doubles as the row counter, and every output
    // is registered so the sink sees a word that only changes on an accepted
    // transfer. The next row word is fetched from the snapshot at the moment
    // the current one is accepted, so live array changes never reach the
    // frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            snap_alive <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_last   <= 1'b0;
            pop_count  <= '0;
            stable     <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        snap_alive <= alive;
                        pop_count  <= popcount(alive);
                        stable     <= (alive == alive_prev);
                        out_row    <= '0;
                        out_data   <= alive[COLS-1:0];
                        out_last   <= (ROWS == 1);
                        out_valid  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_row == LAST_ROW) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            out_row  <= next_row;
                            out_data <= snap_alive[int'(next_row)*COLS +: COLS];
                            out_last <= (next_row == LAST_ROW);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
